// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: FSM encoding and oversampling points.
package uart_pkg;

    localparam int OVERSAMPLE  = 16;
    localparam int MID_SAMPLE  = 7;
    localparam int NB_DATA_DEF = 8;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_START  = 3'd1;
    localparam state_t ST_DATA   = 3'd2;
    localparam state_t ST_PARITY = 3'd3;
    localparam state_t ST_STOP   = 3'd4;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; reset value selectable so
// idle-high lines do not glitch low coming out of reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_d,
    output logic o_q
);

    logic [1:0] ff_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) ff_q <= {2{RST_VAL}};
        else            ff_q <= {ff_q[0], i_d};
    end

    assign o_q = ff_q[1];

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver, LSB-first, 1 start / NB_DATA data / SB_TICK-tick stop.
// Define UART_RX_PARITY_EN to add a parity bit before the stop bit and o_parity_err.
module uart_rx
    import uart_pkg::*;
#(
    parameter int NB_DATA     = NB_DATA_DEF,
    parameter int SB_TICK     = 16,
    parameter int NB_TICK_CNT = 5
`ifdef UART_RX_PARITY_EN
   ,parameter bit PARITY_ODD  = 1'b0
`endif
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_tick,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rx_done,
    output logic               o_frame_err
`ifdef UART_RX_PARITY_EN
   ,output logic               o_parity_err
`endif
);

    localparam int NB_BIT = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

    localparam logic [NB_TICK_CNT-1:0] TICK_MID  = NB_TICK_CNT'(MID_SAMPLE);
    localparam logic [NB_TICK_CNT-1:0] TICK_LAST = NB_TICK_CNT'(OVERSAMPLE - 1);
    localparam logic [NB_TICK_CNT-1:0] TICK_STOP = NB_TICK_CNT'(SB_TICK - 1);
    localparam logic [NB_BIT-1:0]      BIT_LAST  = NB_BIT'(NB_DATA - 1);

`ifdef UART_RX_PARITY_EN
    localparam state_t ST_AFTER_DATA = ST_PARITY;
`else
    localparam state_t ST_AFTER_DATA = ST_STOP;
`endif

    logic                   rx_s;
    state_t                 state_q,    state_d;
    logic [NB_TICK_CNT-1:0] tick_cnt_q, tick_cnt_d;
    logic [NB_BIT-1:0]      bit_cnt_q,  bit_cnt_d;
    logic [NB_DATA-1:0]     shreg_q,    shreg_d;
    logic [NB_DATA-1:0]     data_q,     data_d;
    logic                   done_q,     done_d;
    logic                   ferr_q,     ferr_d;
`ifdef UART_RX_PARITY_EN
    logic                   par_bit_q,  par_bit_d;
    logic                   perr_q,     perr_d;
`endif

    // Idle-high reset keeps a freshly reset receiver from seeing a phantom start bit.
    sync_2ff #(.RST_VAL(1'b1)) u_sync_rx (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_d       (i_rx),
        .o_q       (rx_s)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
            ferr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q  <= 1'b0;
            perr_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            data_q     <= data_d;
            done_q     <= done_d;
            ferr_q     <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_bit_q  <= par_bit_d;
            perr_q     <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (!rx_s) state_d = ST_START;
            ST_START: if (i_tick && tick_cnt_q == TICK_MID)
                          state_d = rx_s ? ST_IDLE : ST_DATA;
            ST_DATA:  if (i_tick && tick_cnt_q == TICK_LAST && bit_cnt_q == BIT_LAST)
                          state_d = ST_AFTER_DATA;
`ifdef UART_RX_PARITY_EN
            ST_PARITY: if (i_tick && tick_cnt_q == TICK_LAST) state_d = ST_STOP;
`endif
            ST_STOP:  if (i_tick && tick_cnt_q == TICK_STOP) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        data_d     = data_q;
        done_d     = 1'b0;
        ferr_d     = ferr_q;
`ifdef UART_RX_PARITY_EN
        par_bit_d  = par_bit_q;
        perr_d     = perr_q;
`endif
        case (state_q)
            // Start edge is taken on any clock so the mid-bit point is tick-accurate.
            ST_IDLE: tick_cnt_d = '0;
            ST_START: if (i_tick) begin
                if (tick_cnt_q == TICK_MID) begin
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                end else begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                end
            end
            ST_DATA: if (i_tick) begin
                if (tick_cnt_q == TICK_LAST) begin
                    tick_cnt_d = '0;
                    shreg_d    = {rx_s, shreg_q[NB_DATA-1:1]};
                    if (bit_cnt_q != BIT_LAST) bit_cnt_d = bit_cnt_q + 1'b1;
                end else begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: if (i_tick) begin
                if (tick_cnt_q == TICK_LAST) begin
                    tick_cnt_d = '0;
                    par_bit_d  = rx_s;
                end else begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                end
            end
`endif
            ST_STOP: if (i_tick) begin
                if (tick_cnt_q == TICK_STOP) begin
                    tick_cnt_d = '0;
                    data_d     = shreg_q;
                    ferr_d     = ~rx_s;
                    done_d     = 1'b1;
`ifdef UART_RX_PARITY_EN
                    perr_d     = (^shreg_q) ^ par_bit_q ^ PARITY_ODD;
`endif
                end else begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                end
            end
            default: tick_cnt_d = '0;
        endcase
    end

    assign o_data      = data_q;
    assign o_rx_done   = done_q;
    assign o_frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign o_parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: tick-every-clock and 1-in-16 tick modes, glitch,
// framing error, mid-frame reset and (with UART_RX_PARITY_EN) parity.
module tb_uart_rx;

    localparam int NB = 8;

    logic          i_clk = 1'b0;
    logic          i_reset_n = 1'b0;
    logic          i_tick = 1'b0;
    logic          i_rx = 1'b1;
    logic [NB-1:0] o_data;
    logic          o_rx_done;
    logic          o_frame_err;
`ifdef UART_RX_PARITY_EN
    logic          o_parity_err;
    logic          par_bit = 1'b0;
    localparam int EXTRA_BIT = 16;
`else
    localparam int EXTRA_BIT = 0;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int last_done_cyc = 0;
    bit tick_all = 1'b1;
    int tdiv     = 0;

    uart_rx #(.NB_DATA(NB)) dut (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_tick      (i_tick),
        .i_rx        (i_rx),
        .o_data      (o_data),
        .o_rx_done   (o_rx_done),
        .o_frame_err (o_frame_err)
`ifdef UART_RX_PARITY_EN
       ,.o_parity_err(o_parity_err)
`endif
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    always @(posedge i_clk) begin
        #1;
        if (o_rx_done === 1'b1) begin
            done_cnt      = done_cnt + 1;
            last_done_cyc = cyc;
        end
    end

    initial begin
        forever begin
            @(negedge i_clk);
            if (tick_all) i_tick = 1'b1;
            else begin
                i_tick = (tdiv == 15);
                tdiv   = (tdiv + 1) % 16;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_frame(input logic [NB-1:0] d, input logic stop, input int bitclk);
        i_rx = 1'b0;
        repeat (bitclk) @(negedge i_clk);
        for (int i = 0; i < NB; i++) begin
            i_rx = d[i];
            repeat (bitclk) @(negedge i_clk);
        end
`ifdef UART_RX_PARITY_EN
        i_rx = par_bit;
        repeat (bitclk) @(negedge i_clk);
`endif
        i_rx = stop;
        repeat (bitclk) @(negedge i_clk);
        i_rx = 1'b1;
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0;
        repeat (3) @(negedge i_clk);
        n_checks++;
        if (o_data !== 8'h00) $display("FAIL reset_data: got %h want 00", o_data); else n_pass++;
        n_checks++;
        if (o_rx_done !== 1'b0) $display("FAIL reset_done: got %b want 0", o_rx_done); else n_pass++;
        n_checks++;
        if (o_frame_err !== 1'b0) $display("FAIL reset_ferr: got %b want 0", o_frame_err); else n_pass++;
`ifdef UART_RX_PARITY_EN
        n_checks++;
        if (o_parity_err !== 1'b0) $display("FAIL reset_perr: got %b want 0", o_parity_err); else n_pass++;
`endif
        i_reset_n = 1'b1;
        repeat (5) @(negedge i_clk);
    endtask

    task automatic test_tick_high();
        int d0, st, lat;
        tick_all = 1'b1;
        repeat (4) @(negedge i_clk);
        d0 = done_cnt;
        st = cyc;
        send_frame(8'hA5, 1'b1, 16);
        repeat (4) @(negedge i_clk);
        lat = last_done_cyc - st;
        n_checks++;
        if (done_cnt !== d0 + 1) $display("FAIL a5_done_count: got %0d want %0d", done_cnt - d0, 1); else n_pass++;
        n_checks++;
        if (o_data !== 8'hA5) $display("FAIL a5_data: got %h want a5", o_data); else n_pass++;
        n_checks++;
        if (o_frame_err !== 1'b0) $display("FAIL a5_ferr: got %b want 0", o_frame_err); else n_pass++;
        n_checks++;
        if (lat < 150 + EXTRA_BIT || lat > 160 + EXTRA_BIT)
            $display("FAIL a5_latency: got %0d want %0d..%0d", lat, 150 + EXTRA_BIT, 160 + EXTRA_BIT);
        else n_pass++;
        n_checks++;
        if (o_rx_done !== 1'b0) $display("FAIL a5_done_width: got %b want 0", o_rx_done); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int d0;
        tick_all = 1'b0;
        repeat (32) @(negedge i_clk);
        d0 = done_cnt;
        send_frame(8'h00, 1'b1, 256);
        n_checks++;
        if (done_cnt !== d0 + 1) $display("FAIL b2b_first_done: got %0d want 1", done_cnt - d0); else n_pass++;
        n_checks++;
        if (o_data !== 8'h00) $display("FAIL b2b_first_data: got %h want 00", o_data); else n_pass++;
        n_checks++;
        if (o_frame_err !== 1'b0) $display("FAIL b2b_first_ferr: got %b want 0", o_frame_err); else n_pass++;
        send_frame(8'hFF, 1'b1, 256);
        repeat (4) @(negedge i_clk);
        n_checks++;
        if (done_cnt !== d0 + 2) $display("FAIL b2b_second_done: got %0d want 2", done_cnt - d0); else n_pass++;
        n_checks++;
        if (o_data !== 8'hFF) $display("FAIL b2b_second_data: got %h want ff", o_data); else n_pass++;
        n_checks++;
        if (o_frame_err !== 1'b0) $display("FAIL b2b_second_ferr: got %b want 0", o_frame_err); else n_pass++;
        tick_all = 1'b1;
        repeat (20) @(negedge i_clk);
    endtask

    task automatic test_start_glitch();
        int d0;
        d0 = done_cnt;
        i_rx = 1'b0;
        repeat (4) @(negedge i_clk);
        i_rx = 1'b1;
        repeat (40) @(negedge i_clk);
        n_checks++;
        if (done_cnt !== d0) $display("FAIL glitch_done: got %0d pulses want 0", done_cnt - d0); else n_pass++;
        n_checks++;
        if (o_data !== 8'hFF) $display("FAIL glitch_data: got %h want ff", o_data); else n_pass++;
        // A real frame right after the glitch must still be received.
        send_frame(8'h5A, 1'b1, 16);
        repeat (4) @(negedge i_clk);
        n_checks++;
        if (o_data !== 8'h5A) $display("FAIL glitch_recover_data: got %h want 5a", o_data); else n_pass++;
    endtask

    task automatic test_frame_err();
        int d0;
        d0 = done_cnt;
        send_frame(8'h3C, 1'b0, 16);
        repeat (30) @(negedge i_clk);
        n_checks++;
        if (done_cnt !== d0 + 1) $display("FAIL ferr_done: got %0d want 1", done_cnt - d0); else n_pass++;
        n_checks++;
        if (o_data !== 8'h3C) $display("FAIL ferr_data: got %h want 3c", o_data); else n_pass++;
        n_checks++;
        if (o_frame_err !== 1'b1) $display("FAIL ferr_flag: got %b want 1", o_frame_err); else n_pass++;
        send_frame(8'hC3, 1'b1, 16);
        repeat (4) @(negedge i_clk);
        n_checks++;
        if (o_frame_err !== 1'b0) $display("FAIL ferr_clear: got %b want 0", o_frame_err); else n_pass++;
        n_checks++;
        if (o_data !== 8'hC3) $display("FAIL ferr_next_data: got %h want c3", o_data); else n_pass++;
        n_checks++;
        if (done_cnt !== d0 + 2) $display("FAIL ferr_next_done: got %0d want 2", done_cnt - d0); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        logic [NB-1:0] d;
        int d0;
        d  = 8'h55;
        d0 = done_cnt;
        i_rx = 1'b0;
        repeat (16) @(negedge i_clk);
        for (int i = 0; i < 3; i++) begin
            i_rx = d[i];
            repeat (16) @(negedge i_clk);
        end
        #2 i_reset_n = 1'b0;
        #1;
        n_checks++;
        if (o_data !== 8'h00) $display("FAIL rst_mid_data: got %h want 00", o_data); else n_pass++;
        n_checks++;
        if (o_rx_done !== 1'b0) $display("FAIL rst_mid_done: got %b want 0", o_rx_done); else n_pass++;
        n_checks++;
        if (o_frame_err !== 1'b0) $display("FAIL rst_mid_ferr: got %b want 0", o_frame_err); else n_pass++;
        i_rx = 1'b1;
        repeat (4) @(negedge i_clk);
        i_reset_n = 1'b1;
        repeat (160) @(negedge i_clk);
        n_checks++;
        if (done_cnt !== d0) $display("FAIL rst_mid_no_done: got %0d pulses want 0", done_cnt - d0); else n_pass++;
        send_frame(8'h81, 1'b1, 16);
        repeat (4) @(negedge i_clk);
        n_checks++;
        if (o_data !== 8'h81) $display("FAIL rst_mid_next_data: got %h want 81", o_data); else n_pass++;
        n_checks++;
        if (done_cnt !== d0 + 1) $display("FAIL rst_mid_next_done: got %0d want 1", done_cnt - d0); else n_pass++;
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        par_bit = 1'b1;
        send_frame(8'h07, 1'b1, 16);
        repeat (4) @(negedge i_clk);
        n_checks++;
        if (o_parity_err !== 1'b0) $display("FAIL par_good: got %b want 0", o_parity_err); else n_pass++;
        n_checks++;
        if (o_data !== 8'h07) $display("FAIL par_data: got %h want 07", o_data); else n_pass++;
        par_bit = 1'b0;
        send_frame(8'h07, 1'b1, 16);
        repeat (4) @(negedge i_clk);
        n_checks++;
        if (o_parity_err !== 1'b1) $display("FAIL par_bad: got %b want 1", o_parity_err); else n_pass++;
        n_checks++;
        if (o_frame_err !== 1'b0) $display("FAIL par_ferr: got %b want 0", o_frame_err); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_tick_high();
        test_back_to_back();
        test_start_glitch();
        test_frame_err();
        test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
